// File: rtl/mm_pkg.sv
// Shared types, dimension-word addresses, region limits and error codes for the
// matrix-multiply job controller.
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_VAL,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OWN_CPU,
        OWN_CTRL,
        OWN_MM
    } owner_e;

    localparam logic [15:0] DIM_R_ADDR = 16'h0000;
    localparam logic [15:0] DIM_K_ADDR = 16'h0004;
    localparam logic [15:0] DIM_N_ADDR = 16'h0008;

    localparam logic [15:0] LIM_RK = 16'd5120;
    localparam logic [15:0] LIM_KN = 16'd4096;
    localparam logic [15:0] LIM_RN = 16'd6144;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_DIM = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;

    // Low-byte part of the dimension check; the caller verifies bits [31:8] are zero.
    function automatic logic dims_ok(input logic [7:0] r, input logic [7:0] k, input logic [7:0] n);
        logic [15:0] rk;
        logic [15:0] kn;
        logic [15:0] rn;
        rk = 16'(r) * 16'(k);
        kn = 16'(k) * 16'(n);
        rn = 16'(r) * 16'(n);
        return (r != 8'd0) && (k != 8'd0) && (n != 8'd0) &&
               (rk <= LIM_RK) && (kn <= LIM_KN) && (rn <= LIM_RN);
    endfunction

    function automatic owner_e owner_of(input state_e s);
        case (s)
            ST_CHK, ST_VAL: return OWN_CTRL;
            ST_RUN:         return OWN_MM;
            default:        return OWN_CPU;
        endcase
    endfunction

endpackage

// File: rtl/mm_ctrl_if.sv
// CPU bus between the bus slave (master side here) and the job controller.
interface mm_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, input cpu_ack, cpu_rdata);
    modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_wdata, output cpu_ack, cpu_rdata);
endinterface

// File: rtl/mm_mem_mux.sv
// Combinational SRAM owner select: routes the granted requester onto the mem_* port
// and gates the read-data returns to the CPU and the accelerator.
module mm_mem_mux
    import mm_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  owner_e            owner,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_ack,
    input  logic [ADDR_W-1:0] ctrl_addr,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic              mm_wen,
    input  logic [DATA_W-1:0] mm_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] mm_rdata
);
    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mm_rdata  = '0;
        case (owner)
            OWN_CPU: begin
                if (cpu_req) begin
                    mem_addr  = cpu_addr;
                    mem_wen   = cpu_we;
                    mem_wdata = cpu_wdata;
                end
            end
            OWN_CTRL: mem_addr = ctrl_addr;
            OWN_MM: begin
                mem_addr  = mm_addr;
                mem_wen   = mm_wen;
                mem_wdata = mm_wdata;
                mm_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

    // Follows the ack, not the owner, so a read granted just before a hand-over still returns data.
    assign cpu_rdata = cpu_ack ? mem_rdata : '0;

endmodule

// File: rtl/mm_ctrl.sv
// Matrix-multiply job controller and SRAM arbiter.
// Optional watchdog on the RUN phase is built when MM_CTRL_TIMEOUT_EN is defined.
module mm_ctrl
    import mm_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int TMO_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              irq_clr,
    output logic              busy,
    output logic              irq,
    output logic [1:0]        err,
    mm_ctrl_if.slave          cpu,
    output logic              mm_run,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic              mm_wen,
    input  logic [DATA_W-1:0] mm_wdata,
    output logic [DATA_W-1:0] mm_rdata,
    input  logic              mm_int,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state_q, state_d;
    logic [1:0]        rd_idx_q, rd_idx_d;
    logic              busy_q, busy_d;
    logic              irq_q, irq_d;
    logic [1:0]        err_q, err_d;
    logic              mm_run_q, mm_run_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [ADDR_W-1:0] ctrl_addr;
    logic              dims_valid;
    logic              tmo_expired;
    owner_e            owner;

    assign owner = owner_of(state_q);

    // R and K are captured the cycle after their reads; N is still on mem_rdata during VAL.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dim
        logic [DATA_W-1:0] dim_q, dim_d;
        always_comb begin
            dim_d = dim_q;
            if (state_q == ST_CHK && rd_idx_q == 2'(gi + 1))
                dim_d = mem_rdata;
        end
        always_ff @(posedge clk) begin
            if (rst) dim_q <= '0;
            else     dim_q <= dim_d;
        end
    end

    assign dims_valid = ~|g_dim[0].dim_q[DATA_W-1:8] && ~|g_dim[1].dim_q[DATA_W-1:8] &&
                        ~|mem_rdata[DATA_W-1:8] &&
                        dims_ok(g_dim[0].dim_q[7:0], g_dim[1].dim_q[7:0], mem_rdata[7:0]);

    always_comb begin
        case (rd_idx_q)
            2'd0:    ctrl_addr = ADDR_W'(DIM_R_ADDR);
            2'd1:    ctrl_addr = ADDR_W'(DIM_K_ADDR);
            default: ctrl_addr = ADDR_W'(DIM_N_ADDR);
        endcase
    end

`ifdef MM_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    always_comb begin
        tmo_d       = (state_q == ST_RUN) ? tmo_q + TMO_W'(1) : '0;
        tmo_expired = (state_q == ST_RUN) && (tmo_d == '1);
    end
    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d  = ST_CHK;
                rd_idx_d = 2'd0;
                err_d    = ERR_OK;
            end
            ST_CHK: begin
                rd_idx_d = rd_idx_q + 2'd1;
                if (rd_idx_q == 2'd2) begin
                    state_d  = ST_VAL;
                    rd_idx_d = 2'd0;
                end
            end
            ST_VAL: begin
                if (dims_valid) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                    err_d   = ERR_DIM;
                end
            end
            ST_RUN: begin
                if (mm_int) begin
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TMO;
                end
            end
            ST_DONE: if (irq_clr) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d    = (state_d == ST_CHK) || (state_d == ST_VAL) || (state_d == ST_RUN);
        irq_d     = (state_d == ST_DONE);
        mm_run_d  = (state_d == ST_RUN);
        cpu_ack_d = cpu.cpu_req && (owner == OWN_CPU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_idx_q  <= 2'd0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
            err_q     <= ERR_OK;
            mm_run_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_idx_q  <= rd_idx_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
            err_q     <= err_d;
            mm_run_q  <= mm_run_d;
            cpu_ack_q <= cpu_ack_d;
        end
    end

    assign busy        = busy_q;
    assign irq         = irq_q;
    assign err         = err_q;
    assign mm_run      = mm_run_q;
    assign cpu.cpu_ack = cpu_ack_q;

    mm_mem_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .owner     (owner),
        .cpu_req   (cpu.cpu_req),
        .cpu_we    (cpu.cpu_we),
        .cpu_addr  (cpu.cpu_addr),
        .cpu_wdata (cpu.cpu_wdata),
        .cpu_ack   (cpu_ack_q),
        .ctrl_addr (ctrl_addr),
        .mm_addr   (mm_addr),
        .mm_wen    (mm_wen),
        .mm_wdata  (mm_wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .cpu_rdata (cpu.cpu_rdata),
        .mm_rdata  (mm_rdata)
    );

endmodule

// File: doc/mm_ctrl.md
# mm_ctrl

Job controller and memory arbiter for the matrix-multiply accelerator. It owns the single-port 16-bit-addressed data SRAM and grants it to either the CPU or the accelerator. On a start pulse it reads and validates the three dimension words, runs the accelerator under a RUN/INT handshake, and raises a sticky interrupt with an error code when the job ends. It sits between the CPU bus slave and the accelerator/SRAM pair.

## Interface
- ADDR_W, 16, byte address width of SRAM and all requesters
- DATA_W, 32, data width
- TMO_W, 20, watchdog counter width (used only with MM_CTRL_TIMEOUT_EN)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job start pulse
- irq_clr  in  1  clears irq and returns to idle
- busy  out  1  job in progress
- irq  out  1  sticky job-done interrupt
- err  out  2  0 ok, 1 bad dimensions, 2 timeout; sticky until next accepted start
- cpu_req / cpu_we  in  1 / 1  CPU access request / write
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data
- cpu_ack / cpu_rdata  out  1 / DATA_W  access done / read data
- mm_run  out  1  RUN to accelerator
- mm_addr / mm_wen / mm_wdata  in  ADDR_W / 1 / DATA_W  accelerator memory port
- mm_rdata  out  DATA_W  SRAM read data to accelerator
- mm_int  in  1  accelerator INT
- mem_addr / mem_wen / mem_wdata  out  ADDR_W / 1 / DATA_W  SRAM port
- mem_rdata  in  DATA_W  SRAM read data, one cycle after address

## Operation
- States:
  - IDLE: CPU owns SRAM.
  - CHK: controller owns SRAM; reads 0x0000, 0x0004, 0x0008.
  - VAL: validates the dimensions.
  - RUN: accelerator owns SRAM.
  - DONE: CPU owns SRAM; irq held.
- IDLE→CHK on start. This clears err.
- start in any other state is ignored.
- CHK: issues reads on 3 consecutive cycles and captures R, K, N one cycle after each read, then goes to VAL.
- VAL: dimensions are valid iff all of the following hold:
  - R, K and N are nonzero.
  - Bits [31:8] of R, K and N are zero.
  - R*K ≤ 5120, K*N ≤ 4096, R*N ≤ 6144. These are 16-bit products of 8-bit operands.
- VAL outcome: valid → RUN with mm_run=1. Invalid → DONE with err=1.
- RUN: mm_run held high. A mm_int high sample → DONE and mm_run=0 on the next edge.
- DONE: irq=1. irq_clr → IDLE with irq=0.
- mem_wen is forced 0 whenever the controller owns SRAM.
- CPU access when CPU owns SRAM: one request is accepted per cycle.
  - cpu_ack is asserted in the cycle after acceptance.
  - cpu_rdata is valid with cpu_ack.
- CPU access when CPU does not own SRAM: cpu_req stalls, with cpu_ack=0 and no SRAM access. The CPU holds the request until it is acked.
- Ownership switches on state edges only. A CPU read accepted in the last IDLE cycle still receives its ack next cycle, with data valid.
- mm_rdata = mem_rdata whenever the current state is RUN, and 0 otherwise.

## Timing
- Reset values: IDLE, busy=0, irq=0, err=0, mm_run=0, cpu_ack=0, cpu_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0, mm_rdata=0.
- Reset mid-job drops mm_run on the same edge.
- busy=1 in CHK, VAL and RUN.
- Latency from start to mm_run=1 is 5 cycles: 1 IDLE→CHK, 3 read cycles, 1 VAL.
- The mem_* mux is combinational from the owner selected by the registered state. There is no extra latency for the accelerator.
- irq_clr and start in the same cycle in DONE: the clear takes effect and start is ignored.
- mm_int while not in RUN is ignored.

## Configuration
- MM_CTRL_TIMEOUT_EN defined:
  - A TMO_W-bit counter clears on entry to RUN and increments every RUN cycle.
  - At all-ones it drops mm_run, sets err=2 and goes to DONE.
  - mm_int in the same cycle as expiry wins: err stays 0.
- MM_CTRL_TIMEOUT_EN undefined: no counter is built, RUN waits indefinitely and err=2 never occurs.

## Structure
- mm_pkg holds:
  - state enum
  - dimension addresses 0x0000/0x0004/0x0008
  - region limits 5120/4096/6144
  - err codes
- Sub-module mm_mem_mux: a purely combinational owner-select mux for the mem_*, cpu_rdata and mm_rdata paths. The FSM and the dimension checker stay in mm_ctrl.

## Test plan
- Dims R=4, K=3, N=2, start, then mm_int after 10 RUN cycles → mm_run rises 5 cycles after start. err=0, irq=1, and irq_clr returns busy=0.
- K=0 → no mm_run, DONE with err=1, irq=1.
- R=80, K=64, N=1 (R*K=5120) → accepted. Then R=81 → err=1.
- CPU read of 0x1000 during RUN → cpu_ack stays low. After DONE it acks one cycle after grant with the SRAM word.
- With MM_CTRL_TIMEOUT_EN and TMO_W=4, no mm_int → mm_run drops after 15 RUN cycles, err=2.
- rst pulse during RUN → mm_run=0, IDLE, irq=0 on the next edge. start during RUN is ignored.
